// File: rtl/cv32e41s_pmp_imp_responder_if.sv
// Interfaces for the PMP implicit-read responder: the xPMP request/response side and the
// read-only OBI side. Signal names keep the responder's port names so the mapping stays obvious.

interface cv32e41s_pmp_imp_if;
  logic        pmp_imp_req_i;
  logic [31:0] pmp_imp_addr_i;
  logic        pmp_imp_rvalid_o;
  logic [31:0] pmp_imp_rdata_b0_o;
  logic [31:0] pmp_imp_rdata_b1_o;
  logic        pmp_imp_err_o;
  logic        busy_o;

  modport master (
    output pmp_imp_req_i, pmp_imp_addr_i,
    input  pmp_imp_rvalid_o, pmp_imp_rdata_b0_o, pmp_imp_rdata_b1_o, pmp_imp_err_o, busy_o
  );

  modport slave (
    input  pmp_imp_req_i, pmp_imp_addr_i,
    output pmp_imp_rvalid_o, pmp_imp_rdata_b0_o, pmp_imp_rdata_b1_o, pmp_imp_err_o, busy_o
  );
endinterface

interface cv32e41s_obi_rd_if;
  logic        obi_req_o;
  logic        obi_gnt_i;
  logic [31:0] obi_addr_o;
  logic        obi_we_o;
  logic [3:0]  obi_be_o;
  logic [2:0]  obi_prot_o;
  logic        obi_rvalid_i;
  logic [31:0] obi_rdata_i;
  logic        obi_err_i;

  modport master (
    output obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_prot_o,
    input  obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i
  );

  modport slave (
    input  obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_prot_o,
    output obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i
  );
endinterface

// File: rtl/cv32e41s_pmp_imp_responder.sv
// Serves xPMP implicit table reads as two OBI word reads (base, base+4) returned together.
// Optional watchdog enabled by defining CV32E41S_PMP_IMP_TIMEOUT_EN.

module cv32e41s_pmp_imp_responder #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input logic               clk,
  input logic               rst_n,
  cv32e41s_pmp_imp_if.slave pmp,
  cv32e41s_obi_rd_if.master obi
);

  if (!(MAX_OUTSTANDING == 1 || MAX_OUTSTANDING == 2) ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("cv32e41s_pmp_imp_responder: illegal parameter value");
  end

  typedef enum logic [2:0] {IDLE, ADDR0, WAIT0, ADDR1, DATA, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [31:0] b0_q, b0_d;
  logic [31:0] b1_q, b1_d;
  logic        err_q, err_d;
  logic [1:0]  out_q, out_d;
  logic [1:0]  rcv_q, rcv_d;
  logic        req_int;
  logic        gnt_acc;
  logic        rsp_acc;
`ifdef CV32E41S_PMP_IMP_TIMEOUT_EN
  logic [15:0] wdog_q, wdog_d;
`endif

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    err_d   = err_q;
    rcv_d   = rcv_q;
    // Never request while the in-flight limit is already used up.
    req_int = ((state_q == ADDR0) || (state_q == ADDR1)) &&
              (out_q < 2'(MAX_OUTSTANDING));
    gnt_acc = req_int && obi.obi_gnt_i;
    rsp_acc = (state_q != IDLE) && obi.obi_rvalid_i && (out_q != 2'd0);
    out_d   = out_q + {1'b0, gnt_acc} - {1'b0, rsp_acc};

    if (rsp_acc) begin
      if (rcv_q == 2'd0) b0_d = obi.obi_rdata_i;
      else               b1_d = obi.obi_rdata_i;
      rcv_d = rcv_q + 2'd1;
      err_d = err_q | obi.obi_err_i;
    end

    unique case (state_q)
      IDLE: begin
        if (pmp.pmp_imp_req_i) begin
          state_d = ADDR0;
          base_d  = pmp.pmp_imp_addr_i & 32'hFFFF_FFFC;
          b0_d    = '0;
          b1_d    = '0;
          err_d   = 1'b0;
          rcv_d   = '0;
        end
      end
      ADDR0: if (gnt_acc) state_d = (MAX_OUTSTANDING == 1) ? WAIT0 : ADDR1;
      WAIT0: if (rcv_d != 2'd0) state_d = ADDR1;
      ADDR1: if (gnt_acc) state_d = DATA;
      DATA:  if (rcv_d == 2'd2) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef CV32E41S_PMP_IMP_TIMEOUT_EN
    wdog_d = wdog_q;
    if (state_q == IDLE) begin
      if (pmp.pmp_imp_req_i) wdog_d = '0;
    end else if (obi.obi_gnt_i || obi.obi_rvalid_i) begin
      wdog_d = '0;
    end else begin
      wdog_d = wdog_q + 16'd1;
    end
    // Abandon the access; clearing outstanding makes any late response a drop.
    if ((state_q inside {ADDR0, WAIT0, ADDR1, DATA}) &&
        (wdog_d == 16'(TIMEOUT_CYCLES))) begin
      state_d = DONE;
      err_d   = 1'b1;
      out_d   = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      err_q   <= 1'b0;
      out_q   <= '0;
      rcv_q   <= '0;
`ifdef CV32E41S_PMP_IMP_TIMEOUT_EN
      wdog_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      err_q   <= err_d;
      out_q   <= out_d;
      rcv_q   <= rcv_d;
`ifdef CV32E41S_PMP_IMP_TIMEOUT_EN
      wdog_q  <= wdog_d;
`endif
    end
  end

  // An errored entry is returned as all-zero so it decodes as PMP OFF.
  assign pmp.pmp_imp_rvalid_o   = (state_q == DONE);
  assign pmp.pmp_imp_err_o      = (state_q == DONE) && err_q;
  assign pmp.pmp_imp_rdata_b0_o = err_q ? 32'h0 : b0_q;
  assign pmp.pmp_imp_rdata_b1_o = err_q ? 32'h0 : b1_q;
  assign pmp.busy_o             = (state_q != IDLE);

  assign obi.obi_req_o  = req_int;
  assign obi.obi_addr_o = (state_q == ADDR1) ? (base_q + 32'd4) : base_q;
  assign obi.obi_we_o   = 1'b0;
  assign obi.obi_be_o   = 4'hF;
  assign obi.obi_prot_o = 3'b111;

endmodule

// File: doc/cv32e41s_pmp_imp_responder.md
Name: cv32e41s_pmp_imp_responder

Overview:
- Serves the implicit PMP table reads issued by the xPMP trie inside the MPU. It is the responder end of the pmp_imp_req/addr/rvalid/rdata_b0/b1 interface.
- Each request is turned into two 32-bit OBI read transactions: word b0 at the base address, word b1 at base+4.
- When both words have arrived, it returns them to the requester together in a single rvalid cycle.
- Sits between the MPU (xPMP) and the data-side OBI memory port or arbiter.

Parameters:
- MAX_OUTSTANDING, 2: maximum OBI reads in flight; legal values 1 (serialized) or 2 (pipelined).
- TIMEOUT_CYCLES, 255: watchdog limit in cycles; only used with the optional feature; range 1..65535.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- pmp_imp_req_i  in  1  request strobe from xPMP; sampled only in IDLE
- pmp_imp_addr_i  in  32  table entry base address; bits [1:0] ignored
- pmp_imp_rvalid_o  out  1  one-cycle pulse: b0/b1/err valid
- pmp_imp_rdata_b0_o  out  32  word at base address
- pmp_imp_rdata_b1_o  out  32  word at base+4
- pmp_imp_err_o  out  1  bus error or timeout; valid with rvalid
- busy_o  out  1  high in every state except IDLE
- obi_req_o  out  1  OBI address-phase request
- obi_gnt_i  in  1  OBI grant
- obi_addr_o  out  32  OBI word address
- obi_we_o  out  1  constant 0
- obi_be_o  out  4  constant 4'hF
- obi_prot_o  out  3  constant 3'b111 (machine mode, data access)
- obi_rvalid_i  in  1  OBI response valid
- obi_rdata_i  in  32  OBI read data
- obi_err_i  in  1  OBI response error

Behaviour:
- Reset: state IDLE; all outputs 0 except obi_be_o=4'hF and obi_prot_o=3'b111; data registers, outstanding count and receive count cleared.
- Address capture: on acceptance, base = {pmp_imp_addr_i[31:2],2'b00}. Beat1 address = base+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
- IDLE: if pmp_imp_req_i, capture base and go to ADDR0. A request in any other state is ignored; the requester must wait for rvalid.
- ADDR0: obi_req_o=1, obi_addr_o=base, held stable until obi_gnt_i. On grant, outstanding+1.
  - MAX_OUTSTANDING=2: go to ADDR1 in the next cycle.
  - MAX_OUTSTANDING=1: go to WAIT0; WAIT0 goes to ADDR1 on the beat0 rvalid.
- ADDR1: obi_req_o=1, obi_addr_o=base+4, held until grant, then go to DATA.
- DATA: wait until receive count reaches 2, then go to DONE.
- Responses (any non-IDLE state):
  - Each obi_rvalid_i with outstanding>0 stores obi_rdata_i into b0 (first) or b1 (second) and ORs obi_err_i into a sticky error flag.
  - obi_rvalid_i with outstanding==0 is dropped and does not change state.
- Same-cycle events: grant of beat1 and rvalid of beat0 in one cycle are both counted, so outstanding stays 1. obi_req_o is never asserted while outstanding==MAX_OUTSTANDING.
- DONE (one cycle):
  - pmp_imp_rvalid_o=1 with registered b0/b1.
  - If the error flag is set: pmp_imp_err_o=1 and both data outputs are forced to 0 (a zero entry decodes as PMP OFF).
  - Return to IDLE. A request in the DONE cycle is not accepted.
- Data outputs are held from DONE until the next acceptance.
- Latency from request cycle to rvalid, with zero-wait grant and rvalid one cycle after grant: 4 cycles (MAX_OUTSTANDING=2), 5 cycles (MAX_OUTSTANDING=1).
- Reset asserted mid-operation: immediate return to IDLE with reset values. Responses arriving after reset are dropped under the outstanding==0 rule.

Optional Feature:
- Macro: CV32E41S_PMP_IMP_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counter clears on acceptance and increments in every non-IDLE cycle without obi_gnt_i or obi_rvalid_i; it clears on either.
  - When it reaches TIMEOUT_CYCLES: go to DONE with pmp_imp_err_o=1 and zero data, drop obi_req_o, and reset outstanding to 0 so late responses are discarded.
- Undefined: no counter; the block waits indefinitely.

Test Plan:
1. MAX_OUTSTANDING=2, zero-wait memory, req with addr=0x0000_1003 -> OBI reads at 0x1000 then 0x1004; rvalid_o exactly 4 cycles after req with b0=mem[0x1000], b1=mem[0x1004], err=0.
2. MAX_OUTSTANDING=1, same stimulus -> beat1 address phase starts only after beat0 rvalid; rvalid_o at cycle 5; obi_req_o never high while a read is outstanding.
3. Grant stalled 3 cycles on beat0 -> obi_addr_o stays 0x1000 and obi_req_o stays high throughout; a second req during busy is ignored; exactly one rvalid_o.
4. obi_err_i=1 on beat1 only -> rvalid_o with err_o=1, b0=b1=0; next request completes with err=0.
5. addr=0xFFFF_FFFC -> beats at 0xFFFFFFFC and 0x00000000; an rst_n pulse between the two grants -> IDLE, busy_o=0, and the stray rvalid is ignored.
6. With CV32E41S_PMP_IMP_TIMEOUT_EN and TIMEOUT_CYCLES=8, grant never given -> rvalid_o with err_o=1 after 8 stalled cycles; obi_req_o deasserts in that cycle.
